// File: rtl/cle_label_engine.sv
// rtl/cle_label_engine.sv - 8-connected component labeling of a 32x32 ROM image into a 1024x8 SRAM label map
module cle_label_engine (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rom_q,
   output logic [6:0] rom_a,
   input  logic [7:0] sram_q,
   output logic [9:0] sram_a,
   output logic [7:0] sram_d,
   output logic       sram_wen,
   output logic       finish
);

   typedef enum logic [2:0] {
      S_LOAD,
      S_CLEAR,
      S_SEED,
      S_GROW,
      S_WRITE,
      S_DONE
   } state_t;

   // Raster index is row*32+col, so bit 0 of every 32-bit chunk is column 0.
   localparam logic [1023:0] NOT_COL0  = {32{32'hFFFF_FFFE}};
   localparam logic [1023:0] NOT_COL31 = {32{32'h7FFF_FFFF}};

   state_t        state;
   logic [1023:0] img;
   logic [1023:0] mask;
   logic [7:0]    label;
   logic [7:0]    ld_cnt;
   logic [6:0]    ld_idx;
   logic [7:0]    rom_rev;
   logic [1023:0] row_dil;
   logic [1023:0] dil;
   logic [1023:0] grow_next;
   logic [9:0]    seed_idx;
   logic [9:0]    next_a;
   logic          unused_sram_q;

   // The label map is write-only from this block.
   assign unused_sram_q = ^sram_q;

   // Byte captured now was addressed two LOAD cycles ago (one address register, one ROM register).
   assign ld_idx = ld_cnt[6:0] - 7'd1;
   assign next_a = sram_a + 10'd1;

   // Bit 7 of a ROM byte is the leftmost pixel, i.e. the lowest raster index.
   always_comb begin
      rom_rev = '0;
      for (int j = 0; j < 8; j++) begin
         rom_rev[j] = rom_q[7 - j];
      end
   end

   // One 8-neighbour dilation step, clipped at row ends and at the top/bottom rows.
   always_comb begin
      row_dil   = mask | ((mask << 1) & NOT_COL0) | ((mask >> 1) & NOT_COL31);
      dil       = row_dil | (row_dil << 32) | (row_dil >> 32);
      grow_next = mask | (dil & img);
   end

   // Priority encoder: scanning downward leaves the lowest set index of img.
   always_comb begin
      seed_idx = '0;
      for (int i = 1023; i >= 0; i--) begin
         if (img[i]) begin
            seed_idx = 10'(i);
         end
      end
   end

   // Main sequencer; every output is a register updated here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_LOAD;
         rom_a    <= '0;
         sram_a   <= '0;
         sram_d   <= '0;
         sram_wen <= 1'b1;
         finish   <= 1'b0;
         img      <= '0;
         mask     <= '0;
         label    <= '0;
         ld_cnt   <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               ld_cnt <= ld_cnt + 8'd1;
               rom_a  <= (ld_cnt < 8'd127) ? rom_a + 7'd1 : 7'd0;
               if (ld_cnt != 8'd0) begin
                  img[{ld_idx, 3'b000} +: 8] <= rom_rev;
               end
               if (ld_cnt == 8'd128) begin
                  state    <= S_CLEAR;
                  sram_a   <= '0;
                  sram_d   <= '0;
                  sram_wen <= 1'b0;
               end
            end
            S_CLEAR: begin
               sram_a <= next_a;
               if (sram_a == 10'd1023) begin
                  sram_wen <= 1'b1;
                  label    <= 8'd1;
                  state    <= S_SEED;
               end
            end
            S_SEED: begin
               if (img == '0) begin
                  finish <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  mask  <= 1024'(1) << seed_idx;
                  state <= S_GROW;
               end
            end
            S_GROW: begin
               if (grow_next == mask) begin
                  state    <= S_WRITE;
                  sram_a   <= '0;
                  sram_d   <= label;
                  sram_wen <= ~mask[0];
               end else begin
                  mask <= grow_next;
               end
            end
            S_WRITE: begin
               sram_a <= next_a;
               if (sram_a == 10'd1023) begin
                  sram_wen <= 1'b1;
                  img      <= img & ~mask;
                  label    <= label + 8'd1;
                  state    <= S_SEED;
               end else begin
                  sram_wen <= ~mask[next_a];
               end
            end
            S_DONE: begin
               finish   <= 1'b1;
               sram_wen <= 1'b1;
            end
            default: state <= S_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_cle_label_engine.sv
// tb/tb_cle_label_engine.sv - directed self-checking bench for cle_label_engine
module tb_cle_label_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] rom_q;
   logic [6:0] rom_a;
   logic [7:0] sram_q;
   logic [9:0] sram_a;
   logic [7:0] sram_d;
   logic       sram_wen;
   logic       finish;

   logic [7:0] rom_mem [128];
   logic [7:0] sram_mem [1024];
   logic [7:0] exp_mem [1024];
   logic       sram_wipe = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int bad_addr;
   logic [7:0] bad_act;
   logic [7:0] bad_exp;

   cle_label_engine dut (
      .clk      (clk),
      .reset    (reset),
      .rom_q    (rom_q),
      .rom_a    (rom_a),
      .sram_q   (sram_q),
      .sram_a   (sram_a),
      .sram_d   (sram_d),
      .sram_wen (sram_wen),
      .finish   (finish)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data registered one cycle after the address.
   always @(posedge clk) rom_q <= rom_mem[rom_a];

   // Synchronous SRAM; a wipe fills it with X so unwritten words stand out.
   always @(posedge clk) begin
      if (sram_wipe) begin
         for (int i = 0; i < 1024; i++) sram_mem[i] <= 'x;
      end else if (sram_wen === 1'b0) begin
         sram_mem[sram_a] <= sram_d;
      end
      sram_q <= sram_mem[sram_a];
   end

   task automatic clear_image();
      for (int i = 0; i < 128; i++) rom_mem[i] = 8'h00;
      for (int i = 0; i < 1024; i++) exp_mem[i] = 8'h00;
   endtask

   task automatic put(input int r, input int c, input logic [7:0] lbl);
      rom_mem[r * 4 + c / 8][7 - (c % 8)] = 1'b1;
      exp_mem[r * 32 + c] = lbl;
   endtask

   task automatic start_run();
      reset     = 1'b0;
      sram_wipe = 1'b1;
      @(posedge clk);
      @(posedge clk);
      sram_wipe = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run_to_finish(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
         if (finish === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic count_map(output int errs);
      errs = 0;
      for (int i = 1023; i >= 0; i--) begin
         if (sram_mem[i] !== exp_mem[i]) begin
            errs++;
            bad_addr = i;
            bad_act  = sram_mem[i];
            bad_exp  = exp_mem[i];
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (rom_a !== 7'd0) $display("FAIL reset_rom_a: got %0d expected 0", rom_a); else n_pass++;
      n_checks++; if (sram_a !== 10'd0) $display("FAIL reset_sram_a: got %0d expected 0", sram_a); else n_pass++;
      n_checks++; if (sram_d !== 8'd0) $display("FAIL reset_sram_d: got %h expected 00", sram_d); else n_pass++;
      n_checks++; if (sram_wen !== 1'b1) $display("FAIL reset_sram_wen: got %b expected 1", sram_wen); else n_pass++;
      n_checks++; if (finish !== 1'b0) $display("FAIL reset_finish: got %b expected 0", finish); else n_pass++;
   endtask

   task automatic test_all_zero();
      int cyc; bit ok; int errs;
      clear_image();
      start_run();
      run_to_finish(cyc, ok);
      n_checks++; if (!ok) $display("FAIL zero_finish: got timeout after %0d cycles expected finish", cyc); else n_pass++;
      // 129 LOAD + 1024 CLEAR + 1 SEED
      n_checks++; if (cyc != 1154) $display("FAIL zero_latency: got %0d cycles expected 1154", cyc); else n_pass++;
      count_map(errs);
      n_checks++; if (errs != 0) $display("FAIL zero_map: %0d bad words, addr %0d got %h expected %h", errs, bad_addr, bad_act, bad_exp); else n_pass++;
      repeat (5) @(posedge clk);
      #1;
      n_checks++; if (finish !== 1'b1) $display("FAIL zero_finish_hold: got %b expected 1", finish); else n_pass++;
      n_checks++; if (sram_wen !== 1'b1) $display("FAIL zero_done_wen: got %b expected 1", sram_wen); else n_pass++;
   endtask

   task automatic test_single_pixel();
      int cyc; bit ok; int errs;
      clear_image();
      put(0, 0, 8'h01);
      start_run();
      run_to_finish(cyc, ok);
      n_checks++; if (!ok) $display("FAIL single_finish: got timeout after %0d cycles expected finish", cyc); else n_pass++;
      // 1154 + GROW 1 + WRITE 1024 + final SEED 1
      n_checks++; if (cyc != 2180) $display("FAIL single_latency: got %0d cycles expected 2180", cyc); else n_pass++;
      n_checks++; if (sram_mem[0] !== 8'h01) $display("FAIL single_word0: got %h expected 01", sram_mem[0]); else n_pass++;
      count_map(errs);
      n_checks++; if (errs != 0) $display("FAIL single_map: %0d bad words, addr %0d got %h expected %h", errs, bad_addr, bad_act, bad_exp); else n_pass++;
   endtask

   task automatic test_diagonal();
      int cyc; bit ok; int errs;
      clear_image();
      put(0, 0, 8'h01);
      put(1, 1, 8'h01);
      start_run();
      run_to_finish(cyc, ok);
      n_checks++; if (!ok) $display("FAIL diag_finish: got timeout after %0d cycles expected finish", cyc); else n_pass++;
      n_checks++; if (sram_mem[33] !== 8'h01) $display("FAIL diag_word33: got %h expected 01", sram_mem[33]); else n_pass++;
      count_map(errs);
      n_checks++; if (errs != 0) $display("FAIL diag_map: %0d bad words, addr %0d got %h expected %h", errs, bad_addr, bad_act, bad_exp); else n_pass++;
   endtask

   task automatic test_border_clip();
      int cyc; bit ok; int errs;
      clear_image();
      put(0, 31, 8'h01);
      put(1, 0, 8'h02);
      start_run();
      run_to_finish(cyc, ok);
      n_checks++; if (!ok) $display("FAIL border_finish: got timeout after %0d cycles expected finish", cyc); else n_pass++;
      n_checks++; if (sram_mem[31] !== 8'h01) $display("FAIL border_word31: got %h expected 01", sram_mem[31]); else n_pass++;
      n_checks++; if (sram_mem[32] !== 8'h02) $display("FAIL border_word32: got %h expected 02", sram_mem[32]); else n_pass++;
      count_map(errs);
      n_checks++; if (errs != 0) $display("FAIL border_map: %0d bad words, addr %0d got %h expected %h", errs, bad_addr, bad_act, bad_exp); else n_pass++;
   endtask

   // Five objects; labels follow the raster index of each object's first pixel.
   task automatic load_five();
      clear_image();
      // U open upward, first pixel (2,2)
      put(2, 2, 8'h01); put(3, 2, 8'h01); put(4, 2, 8'h01); put(4, 3, 8'h01); put(4, 4, 8'h01);
      put(4, 5, 8'h01); put(4, 6, 8'h01); put(3, 6, 8'h01); put(2, 6, 8'h01);
      // horizontal bar, first pixel (2,10)
      for (int c = 10; c <= 14; c++) put(2, c, 8'h02);
      // U open downward, first pixel (6,20)
      for (int c = 20; c <= 24; c++) put(6, c, 8'h03);
      put(7, 20, 8'h03); put(8, 20, 8'h03); put(7, 24, 8'h03); put(8, 24, 8'h03);
      // diagonal chain on the left border, first pixel (8,0)
      put(8, 0, 8'h04); put(9, 1, 8'h04); put(10, 2, 8'h04);
      // U on the right border with the taller arm first, first pixel (11,31)
      put(11, 31, 8'h05); put(12, 31, 8'h05); put(13, 31, 8'h05); put(14, 31, 8'h05);
      put(14, 30, 8'h05); put(14, 29, 8'h05); put(14, 28, 8'h05); put(13, 28, 8'h05); put(12, 28, 8'h05);
   endtask

   task automatic test_five_objects();
      int cyc; bit ok; int errs;
      load_five();
      start_run();
      run_to_finish(cyc, ok);
      n_checks++; if (!ok) $display("FAIL five_finish: got timeout after %0d cycles expected finish", cyc); else n_pass++;
      n_checks++; if (sram_mem[2 * 32 + 6] !== 8'h01) $display("FAIL five_u1_arm: got %h expected 01", sram_mem[2 * 32 + 6]); else n_pass++;
      n_checks++; if (sram_mem[12 * 32 + 28] !== 8'h05) $display("FAIL five_u5_arm: got %h expected 05", sram_mem[12 * 32 + 28]); else n_pass++;
      n_checks++; if (sram_mem[10 * 32 + 2] !== 8'h04) $display("FAIL five_diag_end: got %h expected 04", sram_mem[10 * 32 + 2]); else n_pass++;
      count_map(errs);
      n_checks++; if (errs != 0) $display("FAIL five_map: %0d bad words, addr %0d got %h expected %h", errs, bad_addr, bad_act, bad_exp); else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int cyc; bit ok; int errs;
      load_five();
      start_run();
      // object 1 is written by edge 2185; edge 2188 falls inside GROW of object 2
      repeat (2188) @(posedge clk);
      #2;
      n_checks++; if (sram_d !== 8'h01) $display("FAIL mid_pre_sram_d: got %h expected 01", sram_d); else n_pass++;
      reset = 1'b0;
      #1;
      n_checks++; if (sram_d !== 8'h00) $display("FAIL mid_async_sram_d: got %h expected 00", sram_d); else n_pass++;
      n_checks++; if (sram_wen !== 1'b1) $display("FAIL mid_async_wen: got %b expected 1", sram_wen); else n_pass++;
      n_checks++; if (rom_a !== 7'd0) $display("FAIL mid_async_rom_a: got %0d expected 0", rom_a); else n_pass++;
      n_checks++; if (sram_a !== 10'd0) $display("FAIL mid_async_sram_a: got %0d expected 0", sram_a); else n_pass++;
      n_checks++; if (finish !== 1'b0) $display("FAIL mid_async_finish: got %b expected 0", finish); else n_pass++;
      start_run();
      run_to_finish(cyc, ok);
      n_checks++; if (!ok) $display("FAIL mid_rerun_finish: got timeout after %0d cycles expected finish", cyc); else n_pass++;
      count_map(errs);
      n_checks++; if (errs != 0) $display("FAIL mid_rerun_map: %0d bad words, addr %0d got %h expected %h", errs, bad_addr, bad_act, bad_exp); else n_pass++;
   endtask

   initial begin
      clear_image();
      test_reset();
      test_all_zero();
      test_single_pixel();
      test_diagonal();
      test_border_clip();
      test_five_objects();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cle_label_engine.md
# cle_label_engine

Component labeling engine for a 32×32 binary image. It reads the packed image from an external synchronous 128×8 ROM and finds every 8-connected foreground object. It then writes a per-pixel 8-bit label map into an external synchronous 1024×8 SRAM and raises `finish` when done. It sits between the image ROM and the result SRAM. The SRAM is later inspected as a whole.

## Interface
- Parameters: none. Image size is fixed at 32×32 and labels are 8 bits.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `rom_q` in 8: ROM read data. It is registered in the ROM: valid one cycle after `rom_a` is sampled.
- `rom_a` out 7: ROM address. The ROM is always enabled.
- `sram_q` in 8: SRAM read data. Unused by this block; it never reads the SRAM.
- `sram_a` out 10: SRAM address, equal to `row*32 + col`.
- `sram_d` out 8: SRAM write data.
- `sram_wen` out 1: active-low write enable. The SRAM writes `sram_d` to `sram_a` on the rising edge where `sram_wen` is 0.
- `finish` out 1: done flag. High once the label map is complete; held until reset.

## Operation
Pixel mapping:
- ROM byte `k` holds image row `k/4`, columns `(k%4)*8 .. +7`.
- Bit 7 is the leftmost pixel.
- A value of 1 is foreground.

Required result:
- Every one of the 1024 SRAM words is written.
- Background pixels are written as 0x00.
- Every pixel of one 8-connected object carries the same nonzero label.
- Different objects carry different labels.
- Labels are assigned 1, 2, 3… in order of each object's lowest raster index (row-major).
- Inputs are limited to ≤255 objects. Behaviour beyond 255 objects is unspecified.

Internal state:
- `img[1023:0]`: remaining unlabeled foreground pixels.
- `mask[1023:0]`: the object currently being grown.
- `label[7:0]`: current label value.
- 10-bit scan counter.

FSM states and transitions:
- **LOAD**: issue `rom_a` = 0..127 on consecutive cycles. Capture each `rom_q` one cycle later into the corresponding 8 bits of `img`. After byte 127 is captured, go to CLEAR.
- **CLEAR**: write 0x00 to SRAM addresses 0..1023, one per cycle. Then go to SEED with `label` = 1.
- **SEED**:
  - If `img` is 0, go to DONE.
  - Otherwise set `mask` to one-hot at the lowest set index of `img` (priority encoder), then go to GROW.
- **GROW**: each cycle compute `next = mask | (dilate8(mask) & img)`.
  - `dilate8` ORs each pixel's 8 neighbours.
  - Neighbours are clipped at the image borders: no wrap between row ends, and no wrap between row 0 and row 31.
  - If `next == mask`, go to WRITE. Otherwise set `mask = next`.
- **WRITE**: scan addresses 0..1023.
  - Assert `sram_wen` = 0 with `sram_d` = `label` only where `mask` is set.
  - At the end: `img &= ~mask`, increment `label`, go to SEED.
- **DONE**: `finish` = 1 and `sram_wen` = 1. Stay in DONE until reset.

Width rules:
- `label` is an 8-bit unsigned value.
- `sram_a` is a 10-bit counter. Its wrap 1023→0 marks the end of CLEAR and WRITE.

## Timing
- Reset values: `rom_a` = 0, `sram_a` = 0, `sram_d` = 0, `sram_wen` = 1, `finish` = 0, FSM in LOAD.
- Reset has immediate (asynchronous) effect at any time. Assertion mid-operation aborts the run; the next run restarts from LOAD.
- LOAD takes 129 cycles: 128 addresses plus one cycle of ROM latency.
- CLEAR takes 1024 cycles.
- Per object: 1 SEED cycle, then GROW cycles (≤ object path length + 1), then 1024 WRITE cycles.
- `finish` rises on a clock edge strictly after the edge that performed the last SRAM write. The full label map is in memory when `finish` is observed high.
- Outputs are registered.
- `sram_wen` is high in every cycle that is not an intended write.

## Test plan
- **All-zero ROM**: after ~1155 cycles `finish` = 1. All 1024 SRAM words are 0x00; no word is X.
- **Single pixel**: only ROM byte 0 = 0x80. SRAM[0] = 0x01, all other words 0x00.
- **Diagonal touch is one object**: pixels (0,0) and (1,1) are set (byte 0 = 0x80, byte 4 = 0x40). Both words 0x01 (addresses 0 and 33).
- **Border clip**: pixels (0,31) and (1,0) are set (byte 3 = 0x01, byte 4 = 0x80). Two distinct labels: SRAM[31] = 0x01, SRAM[32] = 0x02.
- **Five separated objects including U shapes**: merged arms of each object share one label. Labels 1–5 are assigned in raster order of first pixel, and background is 0.
- **Reset mid-run**: pull `reset` low during GROW. Outputs return to their reset values immediately. A fresh run after release produces the same correct map.
